// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : lcd_pkg
//  Brief  : Shared types and HD44780 command bytes for the LCD controller.
//  Rev    : 1.0  initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        PWRUP   = 2'd0,
        INIT    = 2'd1,
        REFRESH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        EN_HI = 2'd1,
        WAIT  = 2'd2
    } phase_t;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLR      = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] L1       = 8'h80;
    localparam logic [7:0] L2       = 8'hC0;

    // Refresh slot 0 = L1 cmd, 1..16 = line 1, 17 = L2 cmd, 18..33 = line 2
    localparam logic [5:0] REFRESH_L2_SLOT   = 6'd17;
    localparam logic [5:0] REFRESH_LAST_SLOT = 6'd33;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_xfer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : lcd_byte_xfer
//  Brief  : One HD44780 byte write: SETUP, EN_HI strobe, then post-byte WAIT.
//  Rev    : 1.0  initial release
// ============================================================================
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int EN_HI_CYC    = 25,
    parameter int CMD_WAIT_CYC = 2_500,
    parameter int CLR_WAIT_CYC = 100_000,
    parameter int CNT_W        = 17
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);

    phase_t             r_phase, w_phase_nxt;
    logic               r_busy, w_busy_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_rs;
    logic [7:0]         r_data;
    logic               r_clr;
    logic [CNT_W-1:0]   w_wait_last;
    logic               w_accept;
    logic               w_in_setup;

    assign w_wait_last = r_clr ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
    assign o_done      = r_busy && (r_phase == WAIT) && (r_cnt == w_wait_last);
    assign w_accept    = i_start && (!r_busy || o_done);
    assign w_in_setup  = r_busy && (r_phase == SETUP);

    // The byte is taken live during SETUP so a same-cycle buffer write lands
    assign o_busy     = r_busy;
    assign o_lcd_en   = r_busy && (r_phase == EN_HI);
    assign o_lcd_rs   = w_in_setup ? i_rs   : r_rs;
    assign o_lcd_data = w_in_setup ? i_byte : r_data;

    always_comb begin
        w_phase_nxt = r_phase;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (w_accept) begin
            w_busy_nxt  = 1'b1;
            w_phase_nxt = SETUP;
            w_cnt_nxt   = '0;
        end else if (r_busy) begin
            case (r_phase)
                SETUP: begin
                    w_phase_nxt = EN_HI;
                    w_cnt_nxt   = '0;
                end
                EN_HI: begin
                    if (r_cnt == CNT_W'(EN_HI_CYC - 1)) begin
                        w_phase_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                WAIT: begin
                    if (o_done) begin
                        w_busy_nxt = 1'b0;
                        w_cnt_nxt  = '0;
                    end
                end
                default: begin
                    w_phase_nxt = SETUP;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end else begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= SETUP;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_clr   <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_in_setup) begin
                r_rs   <= i_rs;
                r_data <= i_byte;
                r_clr  <= (i_byte == CLR);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module : lcd_hd44780_ctrl
//  Brief  : HD44780 16x2 init + continuous refresh from a 32-byte frame buffer.
//           Optional frame_done pulse enabled by LCD_FRAME_DONE_EN.
//  Rev    : 1.0  initial release
// ============================================================================
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC    = 1_000_000,
    parameter int EN_HI_CYC    = 25,
    parameter int CMD_WAIT_CYC = 2_500,
    parameter int CLR_WAIT_CYC = 100_000
)(
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
`ifdef LCD_FRAME_DONE_EN
    ,
    output logic       frame_done
`endif
);

    localparam int CNT_MAX = max2(max2(PWRUP_CYC, EN_HI_CYC), max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [5:0]       r_pos;
    logic             r_ready;
    logic [7:0]       r_buf [0:31];

    logic             w_start, w_rs, w_busy, w_done;
    logic [7:0]       w_byte, w_char;
    logic [4:0]       w_rd_addr;

    assign w_rd_addr = (r_pos < REFRESH_L2_SLOT) ? 5'(r_pos - 6'd1) : 5'(r_pos - 6'd2);
    assign w_char    = (wr_en && !RESET && (wr_addr == w_rd_addr)) ? wr_data : r_buf[w_rd_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            PWRUP: begin
                if ((r_cnt == CNT_W'(PWRUP_CYC - 1)) && !w_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_idx == 2'd3) w_state_nxt = REFRESH;
                end
            end
            REFRESH: w_start = w_done;
            default: w_state_nxt = PWRUP;
        endcase
    end

    always_comb begin
        w_rs   = 1'b0;
        w_byte = 8'h00;
        if (r_state == INIT) begin
            case (r_idx)
                2'd0:    w_byte = FUNC_SET;
                2'd1:    w_byte = DISP_ON;
                2'd2:    w_byte = CLR;
                default: w_byte = ENTRY;
            endcase
        end else if (r_state == REFRESH) begin
            if (r_pos == 6'd0) begin
                w_byte = L1;
            end else if (r_pos == REFRESH_L2_SLOT) begin
                w_byte = L2;
            end else begin
                w_rs   = 1'b1;
                w_byte = w_char;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= PWRUP;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_pos   <= 6'd0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == PWRUP) ? r_cnt + CNT_W'(1) : '0;
            if ((r_state == INIT) && w_done) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) r_ready <= 1'b1;
            end
            if (r_state != REFRESH) begin
                r_pos <= 6'd0;
            end else if (w_done) begin
                r_pos <= (r_pos == REFRESH_LAST_SLOT) ? 6'd0 : r_pos + 6'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    lcd_byte_xfer #(
        .EN_HI_CYC    (EN_HI_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .CNT_W        (CNT_W)
    ) u_xfer (
        .clk        (CLOCK_50),
        .rst        (RESET),
        .i_start    (w_start),
        .i_rs       (w_rs),
        .i_byte     (w_byte),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_lcd_rs   (LCD_RS),
        .o_lcd_en   (LCD_EN),
        .o_lcd_data (LCD_DATA)
    );

    assign ready  = r_ready;
    assign LCD_RW = 1'b0;

`ifdef LCD_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_frame_done <= 1'b0;
        else       r_frame_done <= (r_state == REFRESH) && w_done && (r_pos == REFRESH_LAST_SLOT);
    end

    assign frame_done = r_frame_done;
`endif

endmodule
`default_nettype wire
